// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_debounce_pkg;

    // Board defaults: 1 ms-ish sample tick at 50 MHz, four agreeing samples.
    localparam int unsigned DefaultWidth       = 8;
    localparam int unsigned DefaultTickDiv     = 50000;
    localparam int unsigned DefaultStableTicks = 4;

    // Short pair so simulations settle in tens of cycles.
    localparam int unsigned SimTickDiv     = 4;
    localparam int unsigned SimStableTicks = 3;

    // Ceiling log2, never below 1 so every counter has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-in / debounced-word-out bundle between the board pins and the comparator.
interface switch_debounce_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] SWITCH;
    logic [WIDTH-1:0] O;
    logic             VALID;
    logic             CHANGED;

    modport master (
        output SWITCH,
        input  O,
        input  VALID,
        input  CHANGED
    );

    modport slave (
        input  SWITCH,
        output O,
        output VALID,
        output CHANGED
    );
endinterface

// File: rtl/switch_debounce_bit.sv
// One debounced switch bit: 2-flop synchroniser, stable-tick counter, output flop.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DefaultStableTicks
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic TICK,
    input  logic D,
    output logic Q,
    output logic FLIP
);
    localparam int unsigned     CntW    = clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            q_q;
    logic            q_d;

    // Next-state: count ticks that disagree with Q; any agreeing tick restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        FLIP  = 1'b0;
        if (TICK) begin
            if (sync2_q == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                q_d   = sync2_q;
                cnt_d = '0;
                FLIP  = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State: synchroniser, counter and output bit.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            sync1_q <= D;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bank of raw switches into a stable word with VALID and CHANGED flags.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH        = DefaultWidth,
    parameter int unsigned TICK_DIV     = DefaultTickDiv,
    parameter int unsigned STABLE_TICKS = DefaultStableTicks
) (
    input logic              CLK,
    input logic              RESETN,
    switch_debounce_if.slave bus
);
    localparam int unsigned     PreW    = clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
    localparam int unsigned     WarmW   = clog2(STABLE_TICKS + 1);
    localparam logic [WarmW-1:0] WarmLast = WarmW'(STABLE_TICKS - 1);

    logic [PreW-1:0]  pre_q;
    logic [PreW-1:0]  pre_d;
    logic             tick;
    logic [WarmW-1:0] warm_q;
    logic [WarmW-1:0] warm_d;
    logic             valid_q;
    logic             valid_d;
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] o_bits;
    logic [WIDTH-1:0] flip;

    // With TICK_DIV=1 pre_q is stuck at 0, so tick stays high.
    assign tick = (pre_q == PreLast);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .CLK   (CLK),
            .RESETN(RESETN),
            .TICK  (tick),
            .D     (bus.SWITCH[i]),
            .Q     (o_bits[i]),
            .FLIP  (flip[i])
        );
    end

    // Next-state: prescaler wrap, warm-up count, and the VALID-gated change pulse.
    always_comb begin
        pre_d     = tick ? '0 : pre_q + PreW'(1);
        warm_d    = warm_q;
        valid_d   = valid_q;
        if (tick && !valid_q) begin
            // Counter saturates at STABLE_TICKS because VALID stops further increments.
            warm_d = warm_q + WarmW'(1);
            if (warm_q == WarmLast) begin
                valid_d = 1'b1;
            end
        end
        // Uses the pre-edge VALID so flips landing during warm-up stay silent.
        changed_d = valid_q && (|flip);
    end

    // State: prescaler, warm-up tracker and registered flags.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pre_q     <= '0;
            warm_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            warm_q    <= warm_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign bus.O       = o_bits;
    assign bus.VALID   = valid_q;
    assign bus.CHANGED = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench: dut_a at the sim pair (4,3), dut_b at (1,1); shared clock and reset.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    switch_debounce_if #(.WIDTH(8)) bus_a ();
    switch_debounce_if #(.WIDTH(8)) bus_b ();

    switch_debounce #(
        .WIDTH       (8),
        .TICK_DIV    (SimTickDiv),
        .STABLE_TICKS(SimStableTicks)
    ) dut_a (
        .CLK   (clk),
        .RESETN(rst_n),
        .bus   (bus_a)
    );

    switch_debounce #(
        .WIDTH       (8),
        .TICK_DIV    (1),
        .STABLE_TICKS(1)
    ) dut_b (
        .CLK   (clk),
        .RESETN(rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_a.SWITCH = 8'h00;
        bus_b.SWITCH = 8'h0F;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus_a.O !== 8'h00 || bus_a.VALID !== 1'b0 || bus_a.CHANGED !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: O=%h VALID=%b CHANGED=%b, want 00/0/0",
                     bus_a.O, bus_a.VALID, bus_a.CHANGED);
        end
        n_cmp++;
        if (bus_b.O !== 8'h00 || bus_b.VALID !== 1'b0 || bus_b.CHANGED !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: O=%h VALID=%b CHANGED=%b, want 00/0/0",
                     bus_b.O, bus_b.VALID, bus_b.CHANGED);
        end
    endtask

    // Release reset with SWITCH=00 and watch the 12-cycle warm-up.
    task automatic test_idle_warmup();
        int bad_chg;
        int bad_o;
        bad_chg = 0;
        bad_o   = 0;
        rst_n   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus_a.CHANGED !== 1'b0) bad_chg++;
            if (bus_a.O !== 8'h00) bad_o++;
            if (c == 11) begin
                n_cmp++;
                if (bus_a.VALID !== 1'b0) begin
                    n_err++;
                    $display("FAIL warmup_c11: VALID=%b, want 0", bus_a.VALID);
                end
            end
            if (c == 12) begin
                n_cmp++;
                if (bus_a.VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL warmup_c12: VALID=%b, want 1", bus_a.VALID);
                end
            end
        end
        n_cmp++;
        if (bad_chg != 0 || bad_o != 0) begin
            n_err++;
            $display("FAIL idle: CHANGED high %0d cycles, O nonzero %0d cycles, want 0/0",
                     bad_chg, bad_o);
        end
    endtask

    // Clean 00->A5 step: all bits flip together, one pulse, latency 11..15.
    task automatic test_step();
        int first_o;
        int chg_cnt;
        int chg_at;
        int bad;
        first_o      = 0;
        chg_cnt      = 0;
        chg_at       = 0;
        bad          = 0;
        bus_a.SWITCH = 8'hA5;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_a.CHANGED === 1'b1) begin
                chg_cnt++;
                chg_at = n;
            end
            if (first_o == 0 && bus_a.O === 8'hA5) first_o = n;
            else if (first_o == 0 && bus_a.O !== 8'h00) bad++;
        end
        n_cmp++;
        if (first_o < 11 || first_o > 15) begin
            n_err++;
            $display("FAIL step_latency: O=A5 at cycle %0d, want 11..15", first_o);
        end
        n_cmp++;
        if (chg_cnt != 1 || chg_at != first_o) begin
            n_err++;
            $display("FAIL step_changed: %0d pulses, last at %0d, want 1 at %0d",
                     chg_cnt, chg_at, first_o);
        end
        n_cmp++;
        if (bus_a.O !== 8'hA5 || bad != 0) begin
            n_err++;
            $display("FAIL step_value: O=%h stray=%0d, want A5/0", bus_a.O, bad);
        end
    endtask

    // Bit-0 pulses of 2 ticks separated by 1 low tick never qualify; a held level does.
    task automatic test_bounce();
        int bad;
        int first_o;
        int chg_cnt;
        bus_a.SWITCH = 8'h00;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus_a.O !== 8'h00) begin
            n_err++;
            $display("FAIL bounce_prep: O=%h, want 00", bus_a.O);
        end
        bad = 0;
        for (int r = 0; r < 5; r++) begin
            bus_a.SWITCH = 8'h01;
            repeat (8) begin
                @(negedge clk);
                if (bus_a.O !== 8'h00 || bus_a.CHANGED !== 1'b0) bad++;
            end
            bus_a.SWITCH = 8'h00;
            repeat (4) begin
                @(negedge clk);
                if (bus_a.O !== 8'h00 || bus_a.CHANGED !== 1'b0) bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bounce_filtered: %0d disturbed cycles, want 0", bad);
        end
        first_o      = 0;
        chg_cnt      = 0;
        bus_a.SWITCH = 8'h01;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_a.CHANGED === 1'b1) chg_cnt++;
            if (first_o == 0 && bus_a.O === 8'h01) first_o = n;
        end
        n_cmp++;
        if (first_o < 11 || first_o > 15 || chg_cnt != 1) begin
            n_err++;
            $display("FAIL bounce_hold: O=01 at %0d with %0d pulses, want 11..15 and 1",
                     first_o, chg_cnt);
        end
    endtask

    // SWITCH=FF at release: O settles on the same edge VALID rises, with no pulse.
    task automatic test_warmup_ff();
        int chg_cnt;
        chg_cnt = 0;
        rst_n   = 1'b0;
        @(negedge clk);
        bus_a.SWITCH = 8'hFF;
        rst_n        = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus_a.CHANGED === 1'b1) chg_cnt++;
            if (c == 11) begin
                n_cmp++;
                if (bus_a.O !== 8'h00 || bus_a.VALID !== 1'b0) begin
                    n_err++;
                    $display("FAIL warmff_c11: O=%h VALID=%b, want 00/0",
                             bus_a.O, bus_a.VALID);
                end
            end
            if (c == 12) begin
                n_cmp++;
                if (bus_a.O !== 8'hFF || bus_a.VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL warmff_c12: O=%h VALID=%b, want FF/1",
                             bus_a.O, bus_a.VALID);
                end
            end
        end
        n_cmp++;
        if (chg_cnt != 0) begin
            n_err++;
            $display("FAIL warmff_silent: %0d CHANGED pulses, want 0", chg_cnt);
        end
    endtask

    // Reset lands while bit 7 is mid-count; clears asynchronously, then re-settles.
    task automatic test_reset_midcount();
        bus_a.SWITCH = 8'h3C;
        repeat (16) @(negedge clk);
        bus_a.SWITCH = 8'hBC;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (bus_a.O !== 8'h3C) begin
            n_err++;
            $display("FAIL midcount_pre: O=%h, want 3C", bus_a.O);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.O !== 8'h00 || bus_a.VALID !== 1'b0 || bus_a.CHANGED !== 1'b0) begin
            n_err++;
            $display("FAIL midcount_async: O=%h VALID=%b CHANGED=%b, want 00/0/0",
                     bus_a.O, bus_a.VALID, bus_a.CHANGED);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 11) begin
                n_cmp++;
                if (bus_a.VALID !== 1'b0) begin
                    n_err++;
                    $display("FAIL midcount_c11: VALID=%b, want 0", bus_a.VALID);
                end
            end
            if (c == 12) begin
                n_cmp++;
                if (bus_a.O !== 8'hBC || bus_a.VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL midcount_resettle: O=%h VALID=%b, want BC/1",
                             bus_a.O, bus_a.VALID);
                end
            end
        end
    endtask

    // TICK_DIV=1, STABLE_TICKS=1: O follows exactly 3 cycles after the step.
    task automatic test_fast();
        logic [7:0] exp_o;
        logic       exp_c;
        n_cmp++;
        if (bus_b.O !== 8'h0F || bus_b.VALID !== 1'b1) begin
            n_err++;
            $display("FAIL fast_prep: O=%h VALID=%b, want 0F/1", bus_b.O, bus_b.VALID);
        end
        bus_b.SWITCH = 8'hF0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_o = (c >= 3) ? 8'hF0 : 8'h0F;
            exp_c = (c == 3);
            n_cmp++;
            if (bus_b.O !== exp_o || bus_b.CHANGED !== exp_c) begin
                n_err++;
                $display("FAIL fast_c%0d: O=%h CHANGED=%b, want %h/%b",
                         c, bus_b.O, bus_b.CHANGED, exp_o, exp_c);
            end
        end
    endtask

    // Flips on consecutive ticks give back-to-back pulses.
    task automatic test_back_to_back();
        logic [7:0] exp_o;
        logic       exp_c;
        bus_b.SWITCH = 8'h0F;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp_o = (c == 3) ? 8'h0F : 8'hF0;
            exp_c = (c == 3 || c == 4);
            n_cmp++;
            if (bus_b.O !== exp_o || bus_b.CHANGED !== exp_c) begin
                n_err++;
                $display("FAIL b2b_c%0d: O=%h CHANGED=%b, want %h/%b",
                         c, bus_b.O, bus_b.CHANGED, exp_o, exp_c);
            end
            if (c == 1) bus_b.SWITCH = 8'hF0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_idle_warmup();
        test_step();
        test_bounce();
        test_warmup_ff();
        test_reset_midcount();
        repeat (4) @(negedge clk);
        test_fast();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the board-level comparator demos.
- Takes the raw, asynchronous, bouncing SWITCH bank and synchronises each bit into CLK.
- Debounces each bit with a shared sample-tick prescaler and presents a stable operand bus to the comparator's I0/I1 split.
- Also flags when the debounced word changes, so downstream logic (LED latch, result capture) can react once per real change.

Parameters:
- WIDTH, 8, number of switch bits debounced.
- TICK_DIV, 50000, CLK cycles per sample tick (≥1; 1 = tick every cycle).
- STABLE_TICKS, 4, consecutive differing ticks required before an output bit flips (≥1).

Ports:
- CLK  input  1  single system clock; all state on rising edge.
- RESETN  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to CLK.
- SWITCH  input  WIDTH  raw switch levels, asynchronous to CLK.
- O  output  WIDTH  debounced switch word; bits [3:0] and [7:4] feed comparator I0 and I1.
- VALID  output  1  high once the debouncer has completed its post-reset warm-up.
- CHANGED  output  1  one-cycle pulse in the first cycle O shows a new value.

Behaviour:
- Reset values (RESETN=0): O=0, VALID=0, CHANGED=0, sync flops=0, prescaler=0, all bit counters=0, warm-up counter=0.
- Synchroniser: two flops per bit, giving 2 cycles of input latency. S denotes the second-stage value.
- Prescaler counts 0..TICK_DIV-1 and wraps.
  - TICK is high for exactly the one cycle in which count == TICK_DIV-1.
  - With TICK_DIV=1, TICK is permanently high.
- Per-bit cell, per bit i, evaluated only on a clock edge where TICK=1:
  - If S[i] == O[i]: counter := 0.
  - Else if counter == STABLE_TICKS-1: O[i] := S[i], counter := 0.
  - Else: counter := counter+1.
  - Counter width is clog2(STABLE_TICKS+1). It never exceeds STABLE_TICKS-1.
  - Any tick on which the bit matches O (a bounce) restarts the count.
- Latency from a clean SWITCH edge to the O update:
  - 2 cycles of synchronisation, then the STABLE_TICKS-th qualifying tick.
  - The range is [2 + TICK_DIV*(STABLE_TICKS-1) + 1, 2 + TICK_DIV*STABLE_TICKS + 1] cycles.
- Warm-up counter:
  - Saturating; increments on each TICK while VALID=0.
  - VALID goes to 1 on the edge of the STABLE_TICKS-th tick after reset and then stays 1 until reset.
- CHANGED:
  - Registered: high for exactly one cycle, the first cycle in which the updated O is visible.
  - Only generated when VALID was already 1 before that edge; updates during warm-up are silent.
  - Multiple bits flipping on the same tick produce a single pulse.
  - Flips on consecutive ticks produce separate pulses.
- Glitches shorter than STABLE_TICKS ticks never reach O.
- A level held for exactly STABLE_TICKS ticks does reach O.
- Reset asserted mid-count: everything clears at once. After release, prescaler phase restarts at 0 and warm-up repeats.
- O changes only on TICK edges, so no combinational path exists from SWITCH to O.

Decomposition:
- Shared package switch_debounce_pkg:
  - Default constants for TICK_DIV and STABLE_TICKS, including a simulation-speed pair (4, 3).
  - A clog2 helper function for counter widths.
- One natural sub-module: debounce_bit.
  - Contains the 2-flop synchroniser, the stable counter and the O bit register.
  - Ports: CLK, RESETN, TICK, D, Q, FLIP.
  - Instantiated WIDTH times.
- The top holds the prescaler, the warm-up counter and the CHANGED register, which ORs the FLIP outputs gated by VALID.

Test Plan (TICK_DIV=4, STABLE_TICKS=3 unless noted):
- Reset then idle, SWITCH=8'h00 -> O=8'h00, CHANGED never high, VALID rises on the 3rd tick (cycle 12 after reset release).
- After VALID, step SWITCH 8'h00->8'hA5 cleanly -> O=8'hA5 between 11 and 15 cycles after the step, CHANGED high for exactly 1 cycle coincident with O's new value.
- Bounce bit 0 of an 8'h00 word with pulses lasting 2 ticks (8 cycles) separated by 1 low tick, repeated 5 times -> O stays 8'h00, CHANGED stays 0. Then hold high -> O=8'h01 after 3 ticks.
- Change SWITCH to 8'hFF at reset release -> O=8'hFF at warm-up completion, VALID=1, and no CHANGED pulse.
- Assert RESETN=0 for 1 cycle while O=8'h3C and bit 7 is mid-count -> O, VALID, CHANGED = 0 immediately (asynchronous). Re-settle to SWITCH value after warm-up.
- TICK_DIV=1, STABLE_TICKS=1: step SWITCH 8'h0F->8'hF0 -> O follows exactly 3 cycles later with a single CHANGED pulse.
